// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, in-order memory requests and a fetch queue toward decode.
// Predicts JAL as taken, and flushes and drops stale in-flight responses on a resteer.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req_valid,
    output logic [31:0] im_req_addr,
    input  logic        im_req_ready,
    input  logic        im_resp_valid,
    input  logic [31:0] im_resp_data,
    output logic        IF_valid,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst,
    output logic        IF_jump,
    input  logic        DC_ready,
    input  logic        mispredict,
    input  logic [31:0] redirect_pc,
    input  logic        stall
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] kill_cnt;

    logic [31:0]   fq_pc   [FQ_DEPTH];
    logic [31:0]   fq_inst [FQ_DEPTH];
    logic          fq_jump [FQ_DEPTH];
    logic [PW:0]   fq_wr;
    logic [PW:0]   fq_rd;

    // PCs of requests still waiting for their response, oldest at pf_rd
    logic [31:0]   pf_pc [FQ_DEPTH];
    logic [PW-1:0] pf_wr;
    logic [PW-1:0] pf_rd;

    logic [CW-1:0] fq_count;
    logic          fq_not_empty;
    logic [PW-1:0] head;
    logic [31:0]   resp_pc;
    logic          is_jal;
    logic [31:0]   jal_imm;
    logic          resp_keep;
    logic          jal_redir;
    logic          credit_ok;
    logic          req_fire;
    logic          fq_pop;
    logic [CW-1:0] out_after_resp;

    assign fq_count     = fq_wr - fq_rd;
    assign fq_not_empty = (fq_count != '0);
    assign head         = fq_rd[PW-1:0];

    assign resp_pc   = pf_pc[pf_rd];
    assign is_jal    = (im_resp_data[6:2] == 5'b11011);
    assign jal_imm   = {{11{im_resp_data[31]}}, im_resp_data[31], im_resp_data[19:12],
                        im_resp_data[20], im_resp_data[30:21], 1'b0};
    assign resp_keep = im_resp_valid && !mispredict && (kill_cnt == '0);
    assign jal_redir = resp_keep && is_jal;

    // Credits cover both in-flight requests and buffered entries, so the queue never overflows
    assign credit_ok    = ({1'b0, outstanding} + {1'b0, fq_count}) < (CW+1)'(FQ_DEPTH);
    assign im_req_valid = !rst && !stall && !mispredict && !jal_redir && credit_ok;
    assign im_req_addr  = fetch_pc;
    assign req_fire     = im_req_valid && im_req_ready;

    assign IF_valid = !rst && fq_not_empty && !mispredict;
    assign IF_pc    = fq_not_empty ? fq_pc[head]   : 32'h0;
    assign IF_inst  = fq_not_empty ? fq_inst[head] : 32'h0;
    assign IF_jump  = fq_not_empty ? fq_jump[head] : 1'b0;
    assign fq_pop   = IF_valid && DC_ready;

    // Everything still in flight once this cycle's response is consumed is stale after a resteer
    assign out_after_resp = outstanding - CW'(im_resp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            kill_cnt    <= '0;
            fq_wr       <= '0;
            fq_rd       <= '0;
            pf_wr       <= '0;
            pf_rd       <= '0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(im_resp_valid);
            if (req_fire)
                pf_wr <= pf_wr + PW'(1);
            if (im_resp_valid)
                pf_rd <= pf_rd + PW'(1);

            if (mispredict) begin
                fq_wr    <= '0;
                fq_rd    <= '0;
                fetch_pc <= redirect_pc;
                kill_cnt <= out_after_resp;
            end else begin
                if (resp_keep)
                    fq_wr <= fq_wr + (PW+1)'(1);
                if (fq_pop)
                    fq_rd <= fq_rd + (PW+1)'(1);
                if (jal_redir) begin
                    fetch_pc <= resp_pc + jal_imm;
                    kill_cnt <= out_after_resp;
                end else begin
                    if (req_fire)
                        fetch_pc <= fetch_pc + 32'd4;
                    if (im_resp_valid && (kill_cnt != '0))
                        kill_cnt <= kill_cnt - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire)
            pf_pc[pf_wr] <= fetch_pc;
        if (resp_keep) begin
            fq_pc[fq_wr[PW-1:0]]   <= resp_pc;
            fq_inst[fq_wr[PW-1:0]] <= im_resp_data;
            fq_jump[fq_wr[PW-1:0]] <= is_jal;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: a latency-configurable memory model plus scenario tasks
// that compare logged requests/deliveries and live outputs against hand-computed values.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        im_req_valid;
    logic [31:0] im_req_addr;
    logic        im_req_ready;
    logic        im_resp_valid;
    logic [31:0] im_resp_data;
    logic        IF_valid;
    logic [31:0] IF_pc;
    logic [31:0] IF_inst;
    logic        IF_jump;
    logic        DC_ready;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic        stall;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .im_req_valid(im_req_valid), .im_req_addr(im_req_addr), .im_req_ready(im_req_ready),
        .im_resp_valid(im_resp_valid), .im_resp_data(im_resp_data),
        .IF_valid(IF_valid), .IF_pc(IF_pc), .IF_inst(IF_inst), .IF_jump(IF_jump),
        .DC_ready(DC_ready), .mispredict(mispredict), .redirect_pc(redirect_pc), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model state and observation logs
    int          mem_lat = 1;
    logic [31:0] jal_addr = 32'h0;
    logic        jal_en = 1'b0;
    logic        pv [8];
    logic [31:0] pd [8];
    int          cyc = 0;

    logic [31:0] rq_addr [$];
    int          rq_cyc  [$];
    logic [31:0] dl_pc   [$];
    logic [31:0] dl_inst [$];
    logic        dl_jump [$];
    int          dl_cyc  [$];

    localparam logic [31:0] JAL_WORD = 32'h0200006F;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (jal_en && a == jal_addr) return JAL_WORD;
        return {a[29:0], 2'b11};
    endfunction

    initial begin
        im_resp_valid = 1'b0;
        im_resp_data  = 32'h0;
        for (int i = 0; i < 8; i++) begin pv[i] = 1'b0; pd[i] = 32'h0; end
        forever begin
            logic        fire;
            logic [31:0] faddr;
            @(posedge clk);
            fire  = im_req_valid && im_req_ready;
            faddr = im_req_addr;
            if (IF_valid && DC_ready) begin
                dl_pc.push_back(IF_pc); dl_inst.push_back(IF_inst);
                dl_jump.push_back(IF_jump); dl_cyc.push_back(cyc);
            end
            if (fire) begin rq_addr.push_back(faddr); rq_cyc.push_back(cyc); end
            for (int i = 0; i < 7; i++) begin pv[i] = pv[i+1]; pd[i] = pd[i+1]; end
            pv[7] = 1'b0;
            if (rst) begin
                for (int i = 0; i < 8; i++) pv[i] = 1'b0;
            end else if (fire) begin
                pv[mem_lat-1] = 1'b1;
                pd[mem_lat-1] = mem_word(faddr);
            end
            cyc++;
            #1;
            im_resp_valid = pv[0];
            im_resp_data  = pv[0] ? pd[0] : 32'h0;
        end
    end

    task automatic do_reset(input int lat, input logic [31:0] jaddr, input logic jen);
        rst = 1'b1; mispredict = 1'b0; stall = 1'b0;
        mem_lat = lat; jal_addr = jaddr; jal_en = jen;
        repeat (3) @(negedge clk);
        rq_addr.delete(); rq_cyc.delete();
        dl_pc.delete(); dl_inst.delete(); dl_jump.delete(); dl_cyc.delete();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; DC_ready = 1'b1; stall = 1'b0; mispredict = 1'b0;
        redirect_pc = 32'h0; im_req_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (im_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", im_req_valid); end
        checks++; if (IF_valid !== 1'b0) begin errors++; $display("FAIL reset_if_valid: got %b expected 0", IF_valid); end
        checks++; if (IF_pc !== 32'h0 || IF_inst !== 32'h0 || IF_jump !== 1'b0) begin
            errors++; $display("FAIL reset_if_data: got pc=%h inst=%h jump=%b expected zeros", IF_pc, IF_inst, IF_jump); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (im_req_valid !== 1'b1 || im_req_addr !== 32'h0) begin
            errors++; $display("FAIL reset_first_req: got valid=%b addr=%h expected 1/00000000", im_req_valid, im_req_addr); end
    endtask

    task automatic test_sequential();
        DC_ready = 1'b1;
        do_reset(1, 32'h0, 1'b0);
        repeat (12) @(negedge clk);
        checks++; if (rq_addr.size() < 8) begin errors++; $display("FAIL seq_req_count: got %0d expected >=8", rq_addr.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++;
            if (rq_addr[i] !== 32'(i*4) || rq_cyc[i] !== rq_cyc[0] + i) begin
                errors++; $display("FAIL seq_req_%0d: got addr=%h cyc=%0d expected addr=%h cyc=%0d",
                                   i, rq_addr[i], rq_cyc[i], 32'(i*4), rq_cyc[0] + i); end
        end
        checks++; if (dl_pc.size() < 3) begin errors++; $display("FAIL seq_deliver_count: got %0d expected >=3", dl_pc.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dl_pc[i] !== 32'(i*4) || dl_inst[i] !== 32'(i*16 + 3) || dl_jump[i] !== 1'b0) begin
                    errors++; $display("FAIL seq_deliver_%0d: got pc=%h inst=%h jump=%b expected pc=%h inst=%h jump=0",
                                       i, dl_pc[i], dl_inst[i], dl_jump[i], 32'(i*4), 32'(i*16 + 3)); end
            end
            checks++; if (dl_cyc[0] - rq_cyc[0] !== 2) begin
                errors++; $display("FAIL seq_first_latency: got %0d expected 2", dl_cyc[0] - rq_cyc[0]); end
        end
    endtask

    task automatic test_backpressure();
        DC_ready = 1'b0;
        do_reset(1, 32'h0, 1'b0);
        repeat (20) @(negedge clk);
        #1;
        checks++; if (rq_addr.size() !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", rq_addr.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (rq_addr[i] !== 32'(i*4)) begin
                errors++; $display("FAIL bp_req_%0d: got %h expected %h", i, rq_addr[i], 32'(i*4)); end
        end
        checks++; if (im_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", im_req_valid); end
        checks++; if (IF_valid !== 1'b1 || IF_pc !== 32'h0) begin
            errors++; $display("FAIL bp_head: got valid=%b pc=%h expected 1/00000000", IF_valid, IF_pc); end
        DC_ready = 1'b1;
        repeat (12) @(negedge clk);
        checks++; if (dl_pc.size() < 8) begin errors++; $display("FAIL bp_resume_count: got %0d expected >=8", dl_pc.size()); end
        else for (int i = 0; i < 8; i++) begin
            checks++; if (dl_pc[i] !== 32'(i*4)) begin
                errors++; $display("FAIL bp_resume_%0d: got %h expected %h", i, dl_pc[i], 32'(i*4)); end
        end
    endtask

    task automatic test_mispredict();
        DC_ready = 1'b1;
        do_reset(3, 32'h0, 1'b0);
        repeat (2) @(negedge clk);
        stall = 1'b1; mispredict = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (IF_valid !== 1'b0 || im_req_valid !== 1'b0) begin
            errors++; $display("FAIL mp_same_cycle: got if_valid=%b req_valid=%b expected 0/0", IF_valid, im_req_valid); end
        checks++; if (rq_addr.size() !== 2) begin errors++; $display("FAIL mp_outstanding: got %0d expected 2", rq_addr.size()); end
        @(negedge clk);
        mispredict = 1'b0; stall = 1'b0;
        #1;
        checks++; if (im_req_valid !== 1'b1 || im_req_addr !== 32'h100) begin
            errors++; $display("FAIL mp_resteer_req: got valid=%b addr=%h expected 1/00000100", im_req_valid, im_req_addr); end
        repeat (12) @(negedge clk);
        checks++; if (dl_pc.size() < 2) begin errors++; $display("FAIL mp_deliver_count: got %0d expected >=2", dl_pc.size()); end
        else begin
            checks++; if (dl_pc[0] !== 32'h100 || dl_pc[1] !== 32'h104) begin
                errors++; $display("FAIL mp_deliver: got %h,%h expected 00000100,00000104", dl_pc[0], dl_pc[1]); end
        end
    endtask

    task automatic test_jal();
        int stale;
        DC_ready = 1'b1;
        do_reset(3, 32'h8, 1'b1);
        repeat (30) @(negedge clk);
        checks++; if (dl_pc.size() < 5) begin errors++; $display("FAIL jal_deliver_count: got %0d expected >=5", dl_pc.size()); end
        else begin
            checks++; if (dl_pc[0] !== 32'h0 || dl_pc[1] !== 32'h4 || dl_pc[2] !== 32'h8 ||
                          dl_pc[3] !== 32'h28 || dl_pc[4] !== 32'h2C) begin
                errors++; $display("FAIL jal_sequence: got %h,%h,%h,%h,%h expected 0,4,8,28,2c",
                                   dl_pc[0], dl_pc[1], dl_pc[2], dl_pc[3], dl_pc[4]); end
            checks++; if (dl_jump[2] !== 1'b1 || dl_inst[2] !== JAL_WORD) begin
                errors++; $display("FAIL jal_entry: got jump=%b inst=%h expected 1/%h", dl_jump[2], dl_inst[2], JAL_WORD); end
            checks++; if (dl_jump[3] !== 1'b0 || dl_inst[3] !== 32'hA3) begin
                errors++; $display("FAIL jal_target: got jump=%b inst=%h expected 0/000000a3", dl_jump[3], dl_inst[3]); end
        end
        stale = 0;
        foreach (dl_pc[i]) if (dl_pc[i] == 32'hC || dl_pc[i] == 32'h10) stale++;
        checks++; if (stale !== 0) begin errors++; $display("FAIL jal_killed: got %0d stale deliveries expected 0", stale); end
    endtask

    task automatic test_collision();
        int stale;
        DC_ready = 1'b1;
        do_reset(1, 32'h8, 1'b1);
        repeat (3) @(negedge clk);
        mispredict = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (IF_valid !== 1'b0 || im_req_valid !== 1'b0) begin
            errors++; $display("FAIL col_same_cycle: got if_valid=%b req_valid=%b expected 0/0", IF_valid, im_req_valid); end
        checks++; if (dl_pc.size() !== 1) begin errors++; $display("FAIL col_pre_count: got %0d expected 1", dl_pc.size()); end
        @(negedge clk);
        mispredict = 1'b0;
        #1;
        checks++; if (im_req_valid !== 1'b1 || im_req_addr !== 32'h200) begin
            errors++; $display("FAIL col_resteer_req: got valid=%b addr=%h expected 1/00000200", im_req_valid, im_req_addr); end
        repeat (8) @(negedge clk);
        checks++; if (dl_pc.size() < 3) begin errors++; $display("FAIL col_deliver_count: got %0d expected >=3", dl_pc.size()); end
        else begin
            checks++; if (dl_pc[0] !== 32'h0 || dl_pc[1] !== 32'h200 || dl_pc[2] !== 32'h204) begin
                errors++; $display("FAIL col_sequence: got %h,%h,%h expected 0,200,204", dl_pc[0], dl_pc[1], dl_pc[2]); end
        end
        stale = 0;
        foreach (dl_pc[i]) if (dl_pc[i] == 32'h4 || dl_pc[i] == 32'h8 || dl_jump[i]) stale++;
        checks++; if (stale !== 0) begin errors++; $display("FAIL col_flushed: got %0d stale deliveries expected 0", stale); end
    endtask

    task automatic test_stall();
        DC_ready = 1'b0;
        do_reset(1, 32'h0, 1'b0);
        repeat (8) @(negedge clk);
        stall = 1'b1; DC_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (im_req_valid !== 1'b0) begin
                errors++; $display("FAIL stall_req_valid_%0d: got %b expected 0", i, im_req_valid); end
            @(negedge clk);
        end
        checks++; if (rq_addr.size() !== 4) begin errors++; $display("FAIL stall_req_count: got %0d expected 4", rq_addr.size()); end
        checks++; if (dl_pc.size() !== 4) begin errors++; $display("FAIL stall_drain_count: got %0d expected 4", dl_pc.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (dl_pc[i] !== 32'(i*4)) begin
                errors++; $display("FAIL stall_drain_%0d: got %h expected %h", i, dl_pc[i], 32'(i*4)); end
        end
        stall = 1'b0;
        #1;
        checks++; if (IF_valid !== 1'b0 || im_req_valid !== 1'b1 || im_req_addr !== 32'h10) begin
            errors++; $display("FAIL stall_release: got if_valid=%b req_valid=%b addr=%h expected 0/1/00000010",
                               IF_valid, im_req_valid, im_req_addr); end
    endtask

    initial begin
        rst = 1'b1; DC_ready = 1'b1; stall = 1'b0; mispredict = 1'b0;
        redirect_pc = 32'h0; im_req_ready = 1'b1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_mispredict();
        test_jal();
        test_collision();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Front-end fetch stage. Generates the fetch PC, issues in-order requests to instruction memory and buffers the responses in a fetch queue.
- Presents {pc, inst, jump} to the decode/dispatch stage over a valid/ready handshake.
- Statically predicts JAL as taken and redirects fetch itself.
- On a back-end mispredict it flushes, resteers to the redirect PC, and discards stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded at reset
FQ_DEPTH, 4, fetch-queue entries; also the credit limit on outstanding requests plus buffered entries (power of 2, ≥2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
im_req_valid  out  1  instruction-memory request valid
im_req_addr  out  32  request address (word aligned)
im_req_ready  in  1  memory accepts request
im_resp_valid  in  1  response valid; in-order, one per accepted request, latency ≥1 cycle, no backpressure
im_resp_data  in  32  instruction word
IF_valid  out  1  fetch-queue head valid toward decode
IF_pc  out  32  head PC
IF_inst  out  32  head instruction
IF_jump  out  1  head was predicted taken (JAL)
DC_ready  in  1  decode accepts head; already includes back-end stall and mispredict qualification
mispredict  in  1  back-end flush
redirect_pc  in  32  correct PC, valid with mispredict
stall  in  1  back-end stall; blocks new memory requests only

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - Fetch queue empty; in-flight PC FIFO empty; outstanding = 0; kill_cnt = 0.
  - im_req_valid = 0, IF_valid = 0, IF_pc = IF_inst = 0, IF_jump = 0.
  - Reset asserted mid-operation discards everything. Responses to pre-reset requests are not expected; the bench idles memory across reset.
- Counters:
  - outstanding = accepted requests not yet responded (killed ones included).
  - kill_cnt = responses still to be dropped. kill_cnt ≤ outstanding always.
- Request issue:
  - im_req_valid = !stall && !mispredict && !jal_redir && (outstanding + fq_count < FQ_DEPTH).
  - im_req_addr = fetch_pc.
  - On handshake: push fetch_pc into the in-flight PC FIFO; fetch_pc += 4; outstanding++.
- Response:
  - On im_resp_valid, pop the in-flight PC FIFO and decrement outstanding.
  - If kill_cnt > 0: drop the response and decrement kill_cnt.
  - Otherwise: push {pc, data, jump} into the fetch queue. The credit rule guarantees it never overflows.
- JAL prediction:
  - An accepted response with inst[6:2] == 5'b11011 is written with jump = 1.
  - jal_redir = 1 that cycle (combinational; suppresses request issue).
  - fetch_pc <= pc + sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}).
  - kill_cnt <= outstanding after this cycle's response.
  - Non-JAL entries carry jump = 0. Mod-2^32 arithmetic.
- Decode handshake:
  - IF_valid = fq_not_empty && !mispredict.
  - IF_pc, IF_inst and IF_jump are driven from the head entry, and to 0 when the queue is empty.
  - Pop when IF_valid && DC_ready. Head data stays stable while IF_valid && !DC_ready.
- Mispredict (highest priority):
  - Fetch queue emptied and fetch_pc <= redirect_pc.
  - No request issued.
  - Any response arriving the same cycle is dropped.
  - kill_cnt <= outstanding after this cycle's response.
  - No pop that cycle.
  - Overrides a simultaneous JAL redirect. Fetch resumes the next cycle if credits allow.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured, fq_count unchanged.
  - Request and response in the same cycle leave outstanding unchanged.
- Throughput: with single-cycle memory and DC_ready high, one instruction per cycle.
- First-fetch latency: request in cycle N, response in N+L, IF_valid in N+L+1 (registered queue, no bypass).

Test Plan:
- Reset, RESET_PC=0, 1-cycle memory, DC_ready=1 → addresses 0,4,8,… issued back-to-back; IF_pc sequence 0,4,8 with IF_jump=0; first IF_valid 2 cycles after the first request.
- DC_ready=0 for 20 cycles → exactly 4 requests issued, im_req_valid stays 0 afterward, IF_pc holds 0; DC_ready=1 resumes in order with no loss.
- Memory latency 3; mispredict with redirect_pc=0x100 while 2 requests are outstanding → both responses dropped, IF_valid=0 that cycle, next request to 0x100, first delivered IF_pc=0x100.
- Word at 0x8 = JAL +0x20 (0x0200006F) → delivered with IF_jump=1; younger in-flight fetches (0xC, …) dropped; next delivered IF_pc=0x28.
- mispredict in the same cycle as the JAL response and as a pop → JAL not enqueued, no pop, fetch resumes at redirect_pc.
- stall=1 for 5 cycles with a non-empty queue → no new requests, queued entries still drain while DC_ready=1.
